// File: rtl/aip_core_endpoint_pkg.sv
// Shared definitions for the AIP core endpoint: host config codes, STATUS
// bit positions and controller states.
package aip_core_endpoint_pkg;

    localparam logic [4:0] CFG_DATA_IN  = 5'h00;
    localparam logic [4:0] CFG_DATA_OUT = 5'h01;
    localparam logic [4:0] CFG_LENGTH   = 5'h1D;
    localparam logic [4:0] CFG_STATUS   = 5'h1E;
    localparam logic [4:0] CFG_ID       = 5'h1F;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_INT_EN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic done,
                                                input logic int_en);
        logic [31:0] w;
        w              = '0;
        w[STAT_BUSY]   = busy;
        w[STAT_DONE]   = done;
        w[STAT_INT_EN] = int_en;
        return w;
    endfunction

endpackage

// File: rtl/aip_core_endpoint_dpram.sv
// Simple dual-port buffer: one write port, one registered read port with
// read enable. A same-address write and read returns the new word.
module aip_dpram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/aip_core_endpoint.sv
// AIP accelerator endpoint: host register file plus a running-sum engine
// that turns in_buf[0..length-1] into prefix sums in out_buf.
//
// state   | meaning
// IDLE    | waiting for start; host may load buffers and length
// RUN     | one prefix-sum word produced per cycle
// DONE    | single cycle that raises done, then back to IDLE
module aip_core_endpoint
    import aip_core_endpoint_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] CORE_ID = 32'hA1B0_0001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_aip_dataIn,
    input  logic [4:0]  i_aip_config,
    input  logic        i_aip_read,
    input  logic        i_aip_write,
    input  logic        i_aip_start,
    output logic [31:0] o_aip_dataOut,
    output logic        o_aip_int
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             LW      = AW + 1;
    localparam logic [LW-1:0]  LEN_MAX = LW'(DEPTH);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] idx;
    logic [31:0]   acc;
    logic [LW-1:0] length;
    logic          done;
    logic          int_en;
    logic          done_nxt;
    logic          int_en_nxt;
    logic          busy;

    logic          wr_data_in;
    logic          wr_length;
    logic          wr_status;
    logic          rd_data_out;
    logic          start_go;
    logic          last;
    logic [LW-1:0] len_sat;

    logic [AW-1:0] in_raddr;
    logic [31:0]   in_rdata;
    logic [31:0]   out_rdata;
    logic [31:0]   sum;
    logic          run_we;

    logic [31:0]   reg_rdata;
    logic          rd_sel_mem;

    assign busy        = (state != ST_IDLE);
    assign wr_data_in  = i_aip_write && (i_aip_config == CFG_DATA_IN) && !busy;
    assign wr_length   = i_aip_write && (i_aip_config == CFG_LENGTH) && !busy;
    assign wr_status   = i_aip_write && (i_aip_config == CFG_STATUS);
    assign rd_data_out = i_aip_read && (i_aip_config == CFG_DATA_OUT);
    assign start_go    = i_aip_start && !busy;
    assign last        = ({1'b0, idx} == (length - LW'(1)));
    assign len_sat     = (i_aip_dataIn > 32'(DEPTH)) ? LEN_MAX : i_aip_dataIn[LW-1:0];

    // in_buf is read one word ahead so in_rdata already holds in_buf[idx]
    // in every RUN cycle; IDLE keeps word 0 queued for the first cycle.
    assign in_raddr = (state == ST_RUN) ? (idx + AW'(1)) : '0;
    assign sum      = acc + in_rdata;
    assign run_we   = (state == ST_RUN);

    aip_dpram #(.DEPTH(DEPTH), .AW(AW)) u_in_buf (
        .clk   (clk),
        .we    (wr_data_in),
        .waddr (wr_ptr),
        .wdata (i_aip_dataIn),
        .re    (1'b1),
        .raddr (in_raddr),
        .rdata (in_rdata)
    );

    aip_dpram #(.DEPTH(DEPTH), .AW(AW)) u_out_buf (
        .clk   (clk),
        .we    (run_we),
        .waddr (idx),
        .wdata (sum),
        .re    (rd_data_out),
        .raddr (rd_ptr),
        .rdata (out_rdata)
    );

    // DONE setting wins over a host clear landing in the same cycle.
    always_comb begin
        done_nxt   = done;
        int_en_nxt = int_en;
        if (wr_status) begin
            int_en_nxt = i_aip_dataIn[STAT_INT_EN];
            if (i_aip_dataIn[STAT_DONE]) begin
                done_nxt = 1'b0;
            end
        end
        if ((state == ST_IDLE) && start_go) begin
            done_nxt = 1'b0;
        end
        if (state == ST_DONE) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            idx       <= '0;
            acc       <= '0;
            length    <= LEN_MAX;
            done      <= 1'b0;
            int_en    <= 1'b0;
            o_aip_int <= 1'b0;
        end else begin
            done      <= done_nxt;
            int_en    <= int_en_nxt;
            o_aip_int <= done_nxt & int_en_nxt;

            if (wr_data_in) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_data_out) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_length) begin
                length <= len_sat;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        idx    <= '0;
                        acc    <= '0;
                        rd_ptr <= '0;
                        state  <= (length == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= sum;
                    idx <= idx + AW'(1);
                    if (last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register reads are captured here; DATA_OUT comes from the buffer's
    // own read register, which only moves on a DATA_OUT read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_rdata  <= '0;
            rd_sel_mem <= 1'b0;
        end else if (i_aip_read) begin
            rd_sel_mem <= (i_aip_config == CFG_DATA_OUT);
            case (i_aip_config)
                CFG_ID:     reg_rdata <= CORE_ID;
                CFG_STATUS: reg_rdata <= status_word(busy, done, int_en);
                CFG_LENGTH: reg_rdata <= 32'(length);
                default:    reg_rdata <= '0;
            endcase
        end
    end

    assign o_aip_dataOut = rd_sel_mem ? out_rdata : reg_rdata;

endmodule

// File: doc/aip_core_endpoint.md
AIP_CORE_ENDPOINT -- requirements
Module: aip_core_endpoint

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning words per input/output buffer (power of two, min 2).
REQ-002 SHALL have parameter CORE_ID, default 32'hA1P0_0001 replaced by 32'hA1B0_0001, meaning value returned at the ID register.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_aip_dataIn  input  32  write data from the host bridge.
REQ-006 SHALL have port i_aip_config  input  5  register/buffer select.
REQ-007 SHALL have port i_aip_read  input  1  one-cycle read strobe.
REQ-008 SHALL have port i_aip_write  input  1  one-cycle write strobe.
REQ-009 SHALL have port i_aip_start  input  1  one-cycle start strobe.
REQ-010 SHALL have port o_aip_dataOut  output  32  registered read data.
REQ-011 SHALL have port o_aip_int  output  1  level interrupt to the host bridge.

Function
REQ-012 SHALL decode config: 5'h00 DATA_IN (wr), 5'h01 DATA_OUT (rd), 5'h1D LENGTH (rd/wr), 5'h1E STATUS (rd/wr), 5'h1F ID (rd); other codes read 0, writes ignored.
REQ-013 SHALL update o_aip_dataOut on the clock edge after i_aip_read (latency 1) and hold it until the next read.
REQ-014 SHALL store a DATA_IN write at in_buf[wr_ptr] and increment wr_ptr modulo DEPTH; writes while busy ignored, pointer unchanged.
REQ-015 SHALL return out_buf[rd_ptr] on a DATA_OUT read and increment rd_ptr modulo DEPTH.
REQ-016 SHALL, on a LENGTH write, load length (width clog2(DEPTH)+1) saturated to DEPTH and clear wr_ptr and rd_ptr to 0; ignored while busy.
REQ-017 SHALL read STATUS as {29'b0, int_en, done, busy}; STATUS write: bit1=1 clears done, bit2 loads int_en.
REQ-018 SHALL implement FSM IDLE, RUN, DONE.
REQ-019 IDLE: on i_aip_start go to RUN, idx=0, acc=0, clear done and rd_ptr; if length==0 go directly to DONE.
REQ-020 RUN: each cycle out_buf[idx] = acc + in_buf[idx] (mod 2^32), acc updated, idx++; after idx==length-1 go to DONE.
REQ-021 DONE: set done, go to IDLE next cycle; busy=1 in RUN and DONE only.
REQ-022 SHALL drive o_aip_int = done & int_en, registered.
REQ-023 SHALL ignore i_aip_start while busy.
REQ-024 SHALL, if start and a STATUS done-clear write coincide in IDLE, start the run (done cleared once).
REQ-025 SHALL treat simultaneous read and write strobes independently in the same cycle.
REQ-026 SHALL allow DATA_OUT reads while busy (returns current out_buf contents, no hazard protection).

Reset
REQ-027 SHALL, on resetn low, asynchronously force: state IDLE, wr_ptr/rd_ptr/idx 0, acc 0, length DEPTH, done 0, int_en 0, o_aip_dataOut 0, o_aip_int 0; buffers not reset.
REQ-028 SHALL abort a run on reset mid-operation with no done or interrupt afterwards.

Structure
REQ-029 SHALL place config codes, STATUS bit indices and the FSM state enum in package aip_core_endpoint_pkg.
REQ-030 SHALL instantiate sub-module aip_dpram (1 write port, 1 registered read port) twice for in_buf and out_buf.

Verification
REQ-031 Reset then read ID -> 32'hA1B0_0001; STATUS -> 0; LENGTH -> DEPTH.
REQ-032 LENGTH=4, write 1,2,3,4, STATUS=4 (int_en), start -> busy 5 cycles, o_aip_int=1, DATA_OUT reads 1,3,6,10.
REQ-033 LENGTH=0, start -> done and int 1 cycle later, out_buf unchanged.
REQ-034 Start repeated and DATA_IN write during RUN -> ignored; results match single run; wr_ptr unchanged.
REQ-035 Write 17 words with DEPTH=16 -> word 17 overwrites in_buf[0]; in_buf values 32'hFFFF_FFFF,1 -> outputs FFFF_FFFF,0 (wrap).
REQ-036 Assert resetn low during RUN -> all outputs 0, o_aip_int stays 0 after release.
